// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin arbiter in front of a single APB master.
// Latches one single-beat command per grant and runs SETUP/ACCESS with timeout.
module apb_req_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int APB_ADDR_WIDTH = 16,
   parameter int APB_DATA_WIDTH = 8,
   parameter int TIMEOUT        = 15
) (
   input  logic                               pclk,
   input  logic                               preset,
   input  logic [NUM_REQ-1:0]                 i_req,
   input  logic [NUM_REQ-1:0]                 i_write,
   input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]  i_addr,
   input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]  i_wdata,
   output logic [NUM_REQ-1:0]                 o_gnt,
   output logic [NUM_REQ-1:0]                 o_done,
   output logic                               o_err,
   output logic [APB_DATA_WIDTH-1:0]          o_rdata,
   output logic                               o_psel,
   output logic                               o_penable,
   output logic                               o_pwrite,
   output logic [APB_ADDR_WIDTH-1:0]          o_paddr,
   output logic [APB_DATA_WIDTH-1:0]          o_pwdata,
   input  logic                               i_pready,
   input  logic [APB_DATA_WIDTH-1:0]          i_prdata
);

   localparam int AW = APB_ADDR_WIDTH;
   localparam int DW = APB_DATA_WIDTH;
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   win_q, win_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   arb_win;

   logic               psel_d, penable_d, pwrite_d, err_d;
   logic [AW-1:0]      paddr_d;
   logic [DW-1:0]      pwdata_d, rdata_d;
   logic [NUM_REQ-1:0] gnt_d, done_d;

   // Round-robin pick: first active request at or after ptr, wrapping.
   always_comb begin
      int  idx;
      logic found;
      arb_win = ptr_q;
      found   = 1'b0;
      idx     = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && i_req[PW'(idx)]) begin
            arb_win = PW'(idx);
            found   = 1'b1;
         end
      end
   end

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      int sel;
      sel       = int'(arb_win);
      state_d   = state_q;
      ptr_d     = ptr_q;
      win_d     = win_q;
      cnt_d     = cnt_q;
      psel_d    = o_psel;
      penable_d = o_penable;
      pwrite_d  = o_pwrite;
      paddr_d   = o_paddr;
      pwdata_d  = o_pwdata;
      rdata_d   = o_rdata;
      gnt_d     = '0;
      done_d    = '0;
      err_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (|i_req) begin
               win_d    = arb_win;
               pwrite_d = i_write[arb_win];
               paddr_d  = i_addr[sel*AW +: AW];
               pwdata_d = i_wdata[sel*DW +: DW];
               ptr_d    = (sel == NUM_REQ - 1) ? '0 : arb_win + 1'b1;
               psel_d   = 1'b1;
               gnt_d    = NUM_REQ'(1) << arb_win;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            cnt_d     = '0;
            penable_d = 1'b1;
            state_d   = ACCESS;
         end
         ACCESS: begin
            if (i_pready) begin
               if (!o_pwrite) rdata_d = i_prdata;
               psel_d    = 1'b0;
               penable_d = 1'b0;
               done_d    = NUM_REQ'(1) << win_q;
               state_d   = IDLE;
            end else if (cnt_q == CNT_MAX) begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               done_d    = NUM_REQ'(1) << win_q;
               err_d     = 1'b1;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, command and output registers with synchronous reset.
   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         win_q     <= '0;
         cnt_q     <= '0;
         o_psel    <= 1'b0;
         o_penable <= 1'b0;
         o_pwrite  <= 1'b0;
         o_paddr   <= '0;
         o_pwdata  <= '0;
         o_rdata   <= '0;
         o_gnt     <= '0;
         o_done    <= '0;
         o_err     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         win_q     <= win_d;
         cnt_q     <= cnt_d;
         o_psel    <= psel_d;
         o_penable <= penable_d;
         o_pwrite  <= pwrite_d;
         o_paddr   <= paddr_d;
         o_pwdata  <= pwdata_d;
         o_rdata   <= rdata_d;
         o_gnt     <= gnt_d;
         o_done    <= done_d;
         o_err     <= err_d;
      end
   end

endmodule
